// File: rtl/t_vector_driver_pkg.sv
// t_bench_pkg: shared types, constants and golden model for the t netlist stimulus/response stage
package t_bench_pkg;
  localparam int NUM_VECTORS = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] index;
    logic [1:0] expected;
  } pipe_entry_t;
  function automatic logic [1:0] t_golden(input logic [4:0] v);
    logic n;
    n = v[2] & v[3];
    return {~n & (v[1] | v[4]), (v[1] & ~n) | (v[0] & v[2])};
  endfunction
endpackage

// File: rtl/t_vector_driver_if.sv
// t_vector_driver_if: control, netlist and statistics signals of the vector driver
interface t_vector_driver_if;
  logic       start;
  logic       hold;
  logic [1:0] po;
  logic [4:0] pi;
  logic       pi_valid;
  logic       busy;
  logic       done;
  logic [5:0] err_count;
  logic       fail_seen;
  logic [4:0] first_fail;
  modport master (
    input  start, hold, po,
    output pi, pi_valid, busy, done, err_count, fail_seen, first_fail
  );
  modport slave (
    output start, hold, po,
    input  pi, pi_valid, busy, done, err_count, fail_seen, first_fail
  );
endinterface

// File: rtl/t_vector_driver_latency_pipe.sv
// t_latency_pipe: LATENCY-deep shift register of expected-response entries
module t_latency_pipe
  import t_bench_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  pipe_entry_t in_entry,
  output pipe_entry_t out_entry,
  output logic        any_valid
);
  pipe_entry_t stage_q [LATENCY];
  pipe_entry_t stage_d [LATENCY];
  // any_valid looks only behind the output stage: it says whether entries remain once this compare retires
  always_comb begin
    stage_d[0] = in_entry;
    for (int i = 1; i < LATENCY; i++) stage_d[i] = stage_q[i-1];
    any_valid = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) any_valid = any_valid | stage_q[i].valid;
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    else stage_q <= stage_d;
  end
  assign out_entry = stage_q[LATENCY-1];
endmodule

// File: rtl/t_vector_driver.sv
// t_vector_driver: drives all t netlist vectors, checks delayed responses against the golden model
module t_vector_driver
  import t_bench_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input logic               clk,
  input logic               rst,
  t_vector_driver_if.master bus
);
  localparam logic [4:0] LAST_IDX = 5'(NUM_VECTORS - 1);
  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [5:0]  err_q, err_d;
  logic        fail_q, fail_d;
  logic [4:0]  first_q, first_d;
  pipe_entry_t push, out_entry;
  logic        any_valid, issue, mismatch, accept;
  t_latency_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_entry (push),
    .out_entry(out_entry),
    .any_valid(any_valid)
  );
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    fail_d   = fail_q;
    first_d  = first_q;
    push     = '0;
    issue    = (state_q == RUN) && !bus.hold;
    accept   = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    mismatch = out_entry.valid && (bus.po != out_entry.expected);
    if (mismatch) begin
      err_d   = err_q + 6'd1;
      fail_d  = 1'b1;
      first_d = fail_q ? first_q : out_entry.index;
    end
    if (accept) begin
      state_d = RUN;
      idx_d   = '0;
      err_d   = '0;
      fail_d  = 1'b0;
      first_d = '0;
    end
    // idx parks at the last vector so pi holds it through DRAIN
    if (issue) begin
      push    = '{valid: 1'b1, index: idx_q, expected: t_golden(idx_q)};
      idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 5'd1;
      state_d = (idx_q == LAST_IDX) ? DRAIN : RUN;
    end
    if (state_q == DRAIN && !any_valid) state_d = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      first_q <= first_d;
    end
  end
  assign bus.pi         = idx_q;
  assign bus.pi_valid   = issue;
  assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done       = state_q == DONE;
  assign bus.err_count  = err_q;
  assign bus.fail_seen  = fail_q;
  assign bus.first_fail = first_q;
endmodule

// File: tb/tb_t_vector_driver.sv
// tb_t_vector_driver: directed runs of the vector driver at LATENCY 4 and 1 against a modelled netlist
module tb_t_vector_driver;
  logic clk = 1'b0;
  logic rst, start, hold;
  int   mode;
  int   checks = 0, errors = 0;
  int   done4, done1, nvalid, order_bad, hold_bad, zsnap;
  logic [4:0] h4 [4];
  logic [4:0] h1;
  t_vector_driver_if b4 ();
  t_vector_driver_if b1 ();
  t_vector_driver #(.LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.master));
  t_vector_driver #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
  always #5 clk = ~clk;
  function automatic logic [1:0] netlist(input logic [4:0] v, input int m);
    logic a, b, c, d, e, p0, p1;
    {e, d, c, b, a} = v;
    p0 = (b && !(c && d)) || (a && c);
    p1 = (b || e) && !(c && d);
    return (m == 1) ? 2'b00 : (m == 2) ? {~p1, p0} : {p1, p0};
  endfunction
  always @(posedge clk) begin
    h4[0] <= b4.pi;
    h4[1] <= h4[0];
    h4[2] <= h4[1];
    h4[3] <= h4[2];
    h1    <= b1.pi;
  end
  assign b4.start = start;
  assign b4.hold  = hold;
  assign b4.po    = netlist(h4[3], mode);
  assign b1.start = start;
  assign b1.hold  = hold;
  assign b1.po    = netlist(h1, mode);
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input int m, input int hl, input int hh, input int ra,
                     input int sa, input int sb, input bit do_rst);
    mode = m;
    if (do_rst) begin
      rst = 1'b1; start = 1'b0; hold = 1'b0;
      repeat (2) @(posedge clk);
    end else @(posedge clk);
    #1 rst = 1'b0; start = 1'b1; hold = 1'b0;
    done4 = -1; done1 = -1; nvalid = 0; order_bad = 0; hold_bad = 0; zsnap = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      start = (c == sa) || (c == sb);
      hold  = (c >= hl) && (c <= hh);
      rst   = (c == ra);
      @(negedge clk);
      if (b4.pi_valid) begin
        if (b4.pi != 5'(nvalid)) order_bad++;
        nvalid++;
      end
      if (hold && (b4.pi_valid || b4.pi != 5'd9)) hold_bad++;
      if (c == ra + 1)
        zsnap = int'({b4.pi, b4.pi_valid, b4.busy, b4.done, b4.err_count, b4.fail_seen, b4.first_fail});
      if (b4.done && done4 < 0) done4 = c;
      if (b1.done && done1 < 0) done1 = c;
    end
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          int'({b4.pi, b4.pi_valid, b4.busy, b4.done, b4.err_count, b4.fail_seen, b4.first_fail}), 0);
    run(0, 100, 99, -1, -1, -1, 1'b1);
    check("ok_done_cycle", done4, 37);
    check("ok_err", int'(b4.err_count), 0);
    check("ok_fail_seen", int'(b4.fail_seen), 0);
    check("ok_valid_count", nvalid, 32);
    check("ok_pi_order", order_bad, 0);
    check("ok_busy_done", int'({b4.busy, b4.done}), 1);
    run(1, 100, 99, -1, -1, -1, 1'b1);
    check("stuck_err", int'(b4.err_count), 23);
    check("stuck_first", int'(b4.first_fail), 2);
    check("stuck_fail_seen", int'(b4.fail_seen), 1);
    check("stuck_err_l1", int'(b1.err_count), 23);
    run(2, 100, 99, -1, -1, -1, 1'b1);
    check("inv_err", int'(b4.err_count), 32);
    check("inv_first", int'(b4.first_fail), 0);
    check("inv_fail_seen", int'(b4.fail_seen), 1);
    run(0, 10, 12, -1, -1, -1, 1'b1);
    check("hold_done_cycle", done4, 40);
    check("hold_pi_held", hold_bad, 0);
    check("hold_valid_count", nvalid, 32);
    check("hold_err", int'(b4.err_count), 0);
    check("hold_done_l1", done1, 37);
    run(0, 100, 99, 15, -1, -1, 1'b1);
    check("rst_mid_outputs", zsnap, 0);
    check("rst_mid_no_done", done4, -1);
    run(0, 100, 99, -1, -1, -1, 1'b0);
    check("rst_rerun_done", done4, 37);
    check("rst_rerun_valid", nvalid, 32);
    check("rst_rerun_err", int'(b4.err_count), 0);
    run(0, 100, 99, -1, 5, 20, 1'b1);
    check("busy_start_done_l1", done1, 34);
    check("busy_start_done_l4", done4, 37);
    check("busy_start_err_l1", int'(b1.err_count), 0);
    check("busy_start_valid", nvalid, 32);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
